// File: rtl/dac_pkg.sv
// Shared definitions for the multi-channel DAC frame serializer:
// state encoding, default field widths and the frame builder.
package dac_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_LDAC  = 2'd3;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_ADDR_W  = 4;
    localparam int unsigned DEF_CMD_W   = 4;
    localparam int unsigned DEF_FRAME_W = 24;
    localparam int unsigned MAX_FRAME_W = 64;

    function automatic bit frame_w_legal(input int unsigned cmd_w, input int unsigned addr_w,
                                         input int unsigned data_w, input int unsigned frame_w);
        return (cmd_w > 0) && (addr_w > 0) && (data_w > 0) &&
               (frame_w >= cmd_w + addr_w + data_w) && (frame_w <= MAX_FRAME_W);
    endfunction

    // Left-justified {cmd, ch, data} with zero padding below; callers truncate to FRAME_W.
    function automatic logic [MAX_FRAME_W-1:0] build_frame(
        input int unsigned cmd_w, input int unsigned addr_w,
        input int unsigned data_w, input int unsigned frame_w,
        input logic [MAX_FRAME_W-1:0] cmd, input logic [MAX_FRAME_W-1:0] ch,
        input logic [MAX_FRAME_W-1:0] data);
        logic [MAX_FRAME_W-1:0] f;
        f = (cmd << (addr_w + data_w)) | (ch << data_w) | data;
        return f << (frame_w - cmd_w - addr_w - data_w);
    endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// Serial clock divider: CLK_DIV clk cycles per sclk half-period, idle high,
// with one-cycle strobes on the last cycle before each sclk edge.
module dac_sclk_div
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = en && (cnt == CNT_LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (restart || !en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dac_frame_serializer.sv
// Multi-channel DAC frame serializer: accepts {cmd, ch, data} requests and
// shifts a left-justified frame MSB first with sync, sclk and optional LDAC.
module dac_frame_serializer
    import dac_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned CMD_W    = DEF_CMD_W,
    parameter int unsigned FRAME_W  = DEF_FRAME_W,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SYNC_GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [ADDR_W-1:0] in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_ldac,
    output logic              sclk,
    output logic              dout,
    output logic              sync,
    output logic              ldac_n,
    output logic              done,
    output logic              err
);

    if (!frame_w_legal(CMD_W, ADDR_W, DATA_W, FRAME_W) || CLK_DIV < 1 || SYNC_GAP < 1)
    begin : g_bad_params
        $error("dac_frame_serializer: illegal parameter combination");
    end

    localparam int unsigned     BC_W      = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(FRAME_W - 1);
    localparam logic [15:0]     GAP_LAST  = 16'(SYNC_GAP - 1);
    localparam logic [15:0]     LDAC_LAST = 16'(2 * CLK_DIV - 1);

    logic [1:0]         state;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] shreg;
    logic [BC_W-1:0]    bit_cnt;
    logic [15:0]        phase_cnt;
    logic               ldac_pend;
    logic               accept;
    logic               ch_ok;
    logic               restart;
    logic               div_en;
    logic               sclk_rise;
    logic               sclk_fall_unused;

    assign in_ready = (state == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign ch_ok    = 32'(in_ch) < NUM_CH;
    assign restart  = accept && ch_ok;
    assign div_en   = (state == ST_SHIFT);
    assign frame    = FRAME_W'(build_frame(CMD_W, ADDR_W, DATA_W, FRAME_W,
                                           64'(in_cmd), 64'(in_ch), 64'(in_data)));

    dac_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .en      (div_en),
        .sclk    (sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            ldac_pend <= 1'b0;
            sync      <= 1'b1;
            dout      <= 1'b0;
            ldac_n    <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (ch_ok) begin
                            // MSB goes straight to the pin; shreg holds what follows it.
                            dout      <= frame[FRAME_W-1];
                            shreg     <= frame << 1;
                            bit_cnt   <= '0;
                            ldac_pend <= in_ldac;
                            sync      <= 1'b0;
                            state     <= ST_SHIFT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        if (bit_cnt == BIT_LAST) begin
                            state     <= ST_GAP;
                            sync      <= 1'b1;
                            dout      <= 1'b0;
                            done      <= 1'b1;
                            phase_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                            dout    <= shreg[FRAME_W-1];
                            shreg   <= shreg << 1;
                        end
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt <= '0;
                        if (ldac_pend) begin
                            state  <= ST_LDAC;
                            ldac_n <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                ST_LDAC: begin
                    if (phase_cnt == LDAC_LAST) begin
                        ldac_n <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Scoreboard bench for dac_frame_serializer: default instance plus a
// CLK_DIV=1, 20-bit frame instance with zero padding.
module tb_dac_frame_serializer;

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        int          slen;
        int          per;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    logic        in_valid_a = 1'b0, in_ldac_a = 1'b0;
    logic [3:0]  in_cmd_a = '0, in_ch_a = '0;
    logic [15:0] in_data_a = '0;
    logic        in_ready_a, sclk_a, dout_a, sync_a, ldac_n_a, done_a, err_a;

    logic        in_valid_b = 1'b0, in_ldac_b = 1'b0;
    logic [1:0]  in_cmd_b = '0, in_ch_b = '0;
    logic [11:0] in_data_b = '0;
    logic        in_ready_b, sclk_b, dout_b, sync_b, ldac_n_b, done_b, err_b;

    dac_frame_serializer dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_cmd(in_cmd_a), .in_ch(in_ch_a), .in_data(in_data_a), .in_ldac(in_ldac_a),
        .sclk(sclk_a), .dout(dout_a), .sync(sync_a), .ldac_n(ldac_n_a),
        .done(done_a), .err(err_a)
    );

    dac_frame_serializer #(
        .DATA_W(12), .ADDR_W(2), .CMD_W(2), .FRAME_W(20),
        .NUM_CH(4), .CLK_DIV(1), .SYNC_GAP(2)
    ) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_cmd(in_cmd_b), .in_ch(in_ch_b), .in_data(in_data_b), .in_ldac(in_ldac_b),
        .sclk(sclk_b), .dout(dout_b), .sync(sync_b), .ldac_n(ldac_n_b),
        .done(done_b), .err(err_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one loop over both instances, sampling dout on each sclk fall.
    logic [1:0]  m_sync, m_sclk, m_dout, m_done;
    assign m_sync = {sync_b, sync_a};
    assign m_sclk = {sclk_b, sclk_a};
    assign m_dout = {dout_b, dout_a};
    assign m_done = {done_b, done_a};

    bit          m_in[2];
    int          m_len[2], m_n[2], m_last[2], m_gmin[2], m_gmax[2];
    logic [63:0] m_bits[2];
    logic        m_prev[2];

    task automatic end_frame(input int i);
        exp_t e;
        bit   have;
        have = (i == 0) ? (sb_a.size() > 0) : (sb_b.size() > 0);
        chk($sformatf("frame_expected[%0d]", i), 64'(have), 64'd1);
        if (have) begin
            if (i == 0) e = sb_a.pop_front();
            else        e = sb_b.pop_front();
            chk($sformatf("frame_bits[%0d]", i), m_bits[i], e.bits);
            chk($sformatf("frame_nbits[%0d]", i), 64'(m_n[i]), 64'(e.nbits));
            chk($sformatf("sync_low_len[%0d]", i), 64'(m_len[i]), 64'(e.slen));
            chk($sformatf("done_at_end[%0d]", i), 64'(m_done[i]), 64'd1);
            chk($sformatf("sclk_per_min[%0d]", i), 64'(m_gmin[i]), 64'(e.per));
            chk($sformatf("sclk_per_max[%0d]", i), 64'(m_gmax[i]), 64'(e.per));
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_in[i]   = 1'b0;
                m_prev[i] = 1'b1;
            end else begin
                if (!m_sync[i]) begin
                    if (!m_in[i]) begin
                        m_in[i]   = 1'b1;
                        m_len[i]  = 0;
                        m_n[i]    = 0;
                        m_bits[i] = '0;
                        m_last[i] = -1;
                        m_gmin[i] = 1000;
                        m_gmax[i] = 0;
                    end
                    m_len[i]++;
                    if (m_prev[i] && !m_sclk[i]) begin
                        m_bits[i] = {m_bits[i][62:0], m_dout[i]};
                        m_n[i]++;
                        if (m_last[i] >= 0) begin
                            if (int'(cyc) - m_last[i] < m_gmin[i]) m_gmin[i] = int'(cyc) - m_last[i];
                            if (int'(cyc) - m_last[i] > m_gmax[i]) m_gmax[i] = int'(cyc) - m_last[i];
                        end
                        m_last[i] = int'(cyc);
                    end
                end else if (m_in[i]) begin
                    m_in[i] = 1'b0;
                    end_frame(i);
                end else if (m_done[i]) begin
                    chk($sformatf("done_spurious[%0d]", i), 64'(m_done[i]), 64'd0);
                end
                m_prev[i] = m_sclk[i];
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sync"}, 64'(sync_a), 64'd1);
        chk({tag, "_sclk"}, 64'(sclk_a), 64'd1);
        chk({tag, "_dout"}, 64'(dout_a), 64'd0);
        chk({tag, "_ldac_n"}, 64'(ldac_n_a), 64'd1);
        chk({tag, "_done"}, 64'(done_a), 64'd0);
        chk({tag, "_err"}, 64'(err_a), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready_a), 64'd0);
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (!in_ready_a && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_a_wait", 64'(in_ready_a), 64'd1);
    endtask

    task automatic send_a(input logic [3:0] c, input logic [3:0] ch,
                          input logic [15:0] d, input logic l);
        exp_t e;
        wait_ready_a();
        in_cmd_a = c; in_ch_a = ch; in_data_a = d; in_ldac_a = l; in_valid_a = 1'b1;
        e.bits = 64'({c, ch, d}); e.nbits = 24; e.slen = 96; e.per = 4;
        sb_a.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid_a = 1'b0;
        in_ldac_a  = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] c, input logic [1:0] ch,
                          input logic [11:0] d, input logic [63:0] bits);
        exp_t e;
        int n = 0;
        while (!in_ready_b && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_b_wait", 64'(in_ready_b), 64'd1);
        in_cmd_b = c; in_ch_b = ch; in_data_b = d; in_valid_b = 1'b1;
        e.bits = bits; e.nbits = 20; e.slen = 40; e.per = 2;
        sb_b.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid_b = 1'b0;
    endtask

    task automatic wait_done(input bit which_b);
        int n = 0;
        while (!(which_b ? done_b : done_a) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(which_b ? "done_seen_b" : "done_seen_a", 64'(which_b ? done_b : done_a), 64'd1);
    endtask

    // Called at the done cycle; k counts cycles after it.
    task automatic ldac_window(output int nlow, output int first, output logic rdy6);
        nlow = 0; first = -1; rdy6 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (!ldac_n_a) begin
                nlow++;
                if (first < 0) first = k;
            end
            if (k == 6) rdy6 = in_ready_a;
        end
    endtask

    initial begin
        int nl, fi, nsl, nerr, hi, n;
        int unsigned t0, t1;
        logic r6;

        repeat (3) @(negedge clk);
        chk_reset_state("por");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready_a), 64'd1);

        send_a(4'h3, 4'h2, 16'hA5C3, 1'b0);
        wait_done(1'b0);
        ldac_window(nl, fi, r6);
        chk("t1_ldac_low", 64'(nl), 64'd0);

        send_a(4'h3, 4'h2, 16'hA5C3, 1'b1);
        wait_done(1'b0);
        ldac_window(nl, fi, r6);
        chk("t2_ldac_low", 64'(nl), 64'd4);
        chk("t2_ldac_first", 64'(fi), 64'd2);
        chk("t2_ready_after", 64'(r6), 64'd1);

        wait_ready_a();
        in_cmd_a = 4'h3; in_ch_a = 4'h5; in_data_a = 16'h1111; in_valid_a = 1'b1;
        @(negedge clk);
        chk("t3_err", 64'(err_a), 64'd1);
        chk("t3_ready", 64'(in_ready_a), 64'd1);
        chk("t3_sync", 64'(sync_a), 64'd1);
        in_valid_a = 1'b0;
        nsl = 0; nerr = 0;
        repeat (10) begin
            @(negedge clk);
            if (!sync_a) nsl++;
            if (err_a) nerr++;
        end
        chk("t3_sync_low", 64'(nsl), 64'd0);
        chk("t3_err_extra", 64'(nerr), 64'd0);

        wait_ready_a();
        in_cmd_a = 4'h1; in_ch_a = 4'h1; in_data_a = 16'h0001; in_valid_a = 1'b1;
        sb_a.push_back('{bits: 64'h110001, nbits: 24, slen: 96, per: 4});
        sb_a.push_back('{bits: 64'h23FFFF, nbits: 24, slen: 96, per: 4});
        @(posedge clk); #1; t0 = cyc;
        @(negedge clk);
        in_cmd_a = 4'h2; in_ch_a = 4'h3; in_data_a = 16'hFFFF;
        hi = 0; n = 0;
        forever begin
            if (sync_a) hi++;
            if (in_ready_a || n >= 300) break;
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1; t1 = cyc;
        @(negedge clk);
        in_valid_a = 1'b0;
        chk("t4_accept_spacing", 64'(t1 - t0), 64'd99);
        chk("t4_sync_high_between", 64'(hi), 64'd3);
        wait_done(1'b0);

        send_a(4'h3, 4'h2, 16'hA5C3, 1'b0);
        repeat (42) @(posedge clk);
        #1;
        chk("t5_pre_sclk", 64'(sclk_a), 64'd0);
        chk("t5_pre_dout", 64'(dout_a), 64'd1);
        #1 reset = 1'b1;
        if (sb_a.size() > 0) void'(sb_a.pop_front());
        #1;
        chk_reset_state("t5");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_a(4'h5, 4'h1, 16'h1234, 1'b0);
        wait_done(1'b0);

        send_b(2'b10, 2'b01, 12'hABC, 64'h9ABC0);
        wait_done(1'b1);
        send_b(2'b01, 2'b11, 12'h001, 64'h70010);
        wait_done(1'b1);

        repeat (20) @(negedge clk);
        chk("sb_a_drained", 64'(sb_a.size()), 64'd0);
        chk("sb_b_drained", 64'(sb_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
